serial_sub_ctrl: RTL

//   Bit-serial N-bit subtractor: one full-subtractor cell, sequenced by an FSM.

---
 rtl/sub_pkg.sv | 15 +
 rtl/fs_bit.sv | 13 +
 rtl/serial_sub_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } sub_state_t;

   // Counter width able to hold values 0..w.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow.
module fs_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor: one fs_bit cell stepped LSB first by a small FSM,
// with valid/ready handshakes on operand input and result output.
module serial_sub_ctrl
   import sub_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_b_in,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_diff,
   output logic         o_borrow_out,
   output logic         o_busy
);

   localparam int unsigned CW = cnt_width(W);

   sub_state_t r_state;
   sub_state_t w_state_nxt;

   logic [W-1:0]  r_a_sh;
   logic [W-1:0]  r_b_sh;
   logic [W-1:0]  r_res;
   logic [CW-1:0] r_cnt;
   logic          r_borrow;
   logic          r_bout;

   logic          w_d;
   logic          w_bout;
   logic          w_accept;
   logic          w_last;
   logic [W:0]    w_res_cat;

   fs_bit u_cell (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   assign w_accept  = (r_state == IDLE) && i_in_valid;
   assign w_last    = (r_state == RUN) && (r_cnt == CW'(W - 1));
   // New diff bit enters at the MSB; after W steps bit 0 has reached res[0].
   assign w_res_cat = {w_d, r_res};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (i_in_valid) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    if (i_out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      if (!i_rst) begin
         unique case (r_state)
            IDLE:    o_in_ready  = 1'b1;
            RUN:     o_busy      = 1'b1;
            DONE:    o_out_valid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
      end else if (w_accept) begin
         r_a_sh   <= i_a;
         r_b_sh   <= i_b;
         r_borrow <= i_b_in;
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_a_sh   <= r_a_sh >> 1;
         r_b_sh   <= r_b_sh >> 1;
         r_res    <= w_res_cat[W:1];
         r_borrow <= w_bout;
         if (w_last) begin
            r_cnt  <= '0;
            r_bout <= w_bout;
         end else begin
            r_cnt  <= r_cnt + CW'(1);
         end
      end
   end

   assign o_diff       = r_res;
   assign o_borrow_out = r_bout;

endmodule
